cs_loader_sequencer: RTL

//  Parametrised control-store engine for ECLair: copies microcode from EPROM to

---
 rtl/cs_loader_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cs_loader_sequencer.sv
// Control-store engine: copies microcode EPROM into RAM after reset, optionally
// read-back verifies it, then sequences microinstructions into a registered word.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_COPY   | RAM write strobe low, stepping cs_addr 0..DEPTH-1 copying ROM words
// S_VERIFY | comparing RAM read-back against ROM, one address per cycle
// S_RUN    | sequencing microinstructions, cs_ready high
// S_HALT   | HALT_ADDR reached, outputs frozen until reset
// S_FAULT  | verify mismatch or parity error, outputs frozen until reset
module cs_loader_sequencer #(
    parameter int                    CS_WIDTH   = 64,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    NEXT_LSB   = 25,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR  = 8'hFE,
    parameter bit                    VERIFY     = 1'b1,
    parameter bit                    PARITY     = 1'b0
) (
    input  logic                  clk,
    input  logic                  _reset,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] ir,
    input  logic [CS_WIDTH-1:0]   rom_data,
    input  logic [CS_WIDTH-1:0]   ram_rdata,
    output logic [ADDR_WIDTH-1:0] cs_addr,
    output logic [CS_WIDTH-1:0]   ram_wdata,
    output logic                  ram__w,
    output logic [CS_WIDTH-1:0]   cs_data,
    output logic                  cs_ready,
    output logic                  halted,
    output logic                  fault,
    output logic [ADDR_WIDTH-1:0] fault_addr
);

    typedef enum logic [2:0] {
        S_COPY   = 3'd0,
        S_VERIFY = 3'd1,
        S_RUN    = 3'd2,
        S_HALT   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [CS_WIDTH-1:0]   data_nxt;
    logic [ADDR_WIDTH-1:0] faddr_nxt;
    logic [ADDR_WIDTH-1:0] next_field;
    logic                  parity_bad;

    assign next_field = ram_rdata[NEXT_LSB +: ADDR_WIDTH];
    assign parity_bad = PARITY && !(^ram_rdata);

    always_ff @(posedge clk) begin
        if (!_reset) begin
            state      <= S_COPY;
            cs_addr    <= '0;
            cs_data    <= '0;
            fault_addr <= '0;
        end else begin
            state      <= state_nxt;
            cs_addr    <= addr_nxt;
            cs_data    <= data_nxt;
            fault_addr <= faddr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = cs_addr;
        data_nxt  = cs_data;
        faddr_nxt = fault_addr;
        case (state)
            S_COPY: begin
                // Wrap to 0 is the natural increment; the verify pass starts there.
                addr_nxt = cs_addr + 1'b1;
                if (cs_addr == LAST_ADDR) begin
                    if (VERIFY) begin
                        state_nxt = S_VERIFY;
                    end else begin
                        state_nxt = S_RUN;
                        addr_nxt  = START_ADDR;
                    end
                end
            end
            S_VERIFY: begin
                if (ram_rdata != rom_data) begin
                    state_nxt = S_FAULT;
                    faddr_nxt = cs_addr;
                end else if (cs_addr == LAST_ADDR) begin
                    state_nxt = S_RUN;
                    addr_nxt  = START_ADDR;
                end else begin
                    addr_nxt = cs_addr + 1'b1;
                end
            end
            S_RUN: begin
                // Parity fault takes priority over halt detection on the same edge.
                if (advance && parity_bad) begin
                    state_nxt = S_FAULT;
                    faddr_nxt = cs_addr;
                end else if (cs_addr == HALT_ADDR) begin
                    state_nxt = S_HALT;
                end else if (advance) begin
                    data_nxt = ram_rdata;
                    addr_nxt = (next_field == '0) ? ir : next_field;
                end
            end
            default: ;
        endcase
    end

    // Strobe is gated by reset so no write occurs while reset is held.
    assign ram__w    = !((state == S_COPY) && _reset);
    assign ram_wdata = rom_data;
    assign cs_ready  = (state == S_RUN) || (state == S_HALT);
    assign halted    = (state == S_HALT);
    assign fault     = (state == S_FAULT);

endmodule
